// File: rtl/clock_timekeeper.sv
// hh:mm:ss timekeeping core: key debounce, 1 s prescaler, RUN/SET editing FSM, BCD display outputs.
// Latency: key edge to field update is 2 sync + DB_CYCLES + 1 cycles; outputs are combinational from state registers.
// Backpressure: none; keys are sampled every cycle and the tick pulses are single-cycle and unconditional.
module clock_timekeeper #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 500_000,
    parameter int HOUR_24   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key0,
    input  logic        key1,
    input  logic        key2,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic [1:0]  mode,
    output logic        sec_tick,
    output logic        day_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [2:0]    key_raw;
    logic [2:0]    press;

    logic [PW-1:0] presc;
    logic [4:0]    hr;
    logic [5:0]    mn;
    logic [5:0]    sc;

    logic          edit_inc;
    logic          edit_dec;
    logic [4:0]    disp_hr;

    assign key_raw = {key2, key1, key0};

    // Step a field by one with wrap-around inside 0..max, no carry out.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max, input logic up);
        logic [5:0] r;
        if (up) begin
            r = (v == max) ? 6'd0 : v + 6'd1;
        end else begin
            r = (v == 6'd0) ? max : v - 6'd1;
        end
        return r;
    endfunction

    // Binary 0..59 to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 5; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_db
        logic          sync1;
        logic          sync2;
        logic          level;
        logic          pulse;
        logic [DW-1:0] cnt;

        // Two-flop synchroniser for the asynchronous key input; idle level is released (1).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= key_raw[g];
                sync2 <= sync1;
            end
        end

        // Accept a new level after DB_CYCLES consecutive differing samples; pulse only on press.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level <= 1'b1;
                cnt   <= '0;
                pulse <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    pulse <= ~sync2;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end
        end

        assign press[g] = pulse;
    end

    // Mode key steps the FSM round RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
    always_comb begin
        state_nxt = state;
        if (press[0]) begin
            case (state)
                ST_RUN:     state_nxt = ST_SET_HR;
                ST_SET_HR:  state_nxt = ST_SET_MIN;
                ST_SET_MIN: state_nxt = ST_SET_SEC;
                default:    state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Edits apply only in SET states; a coincident mode press or both edit keys cancel the edit.
    assign edit_inc = (state != ST_RUN) && press[1] && !press[2] && !press[0];
    assign edit_dec = (state != ST_RUN) && press[2] && !press[1] && !press[0];

    // Prescaler and time registers: count and carry in RUN, frozen and editable otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            hr       <= 5'd0;
            mn       <= 6'd0;
            sc       <= 6'd0;
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_tick <= 1'b0;
            if (state == ST_RUN && !press[0]) begin
                if (presc == PRESC_LAST) begin
                    presc    <= '0;
                    sec_tick <= 1'b1;
                    if (sc == 6'd59) begin
                        sc <= 6'd0;
                        if (mn == 6'd59) begin
                            mn <= 6'd0;
                            if (hr == 5'd23) begin
                                hr       <= 5'd0;
                                day_tick <= 1'b1;
                            end else begin
                                hr <= hr + 5'd1;
                            end
                        end else begin
                            mn <= mn + 6'd1;
                        end
                    end else begin
                        sc <= sc + 6'd1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end else begin
                // Held at zero outside RUN so the first tick after RUN is a full period away.
                presc <= '0;
                if (edit_inc || edit_dec) begin
                    case (state)
                        ST_SET_HR:  hr <= 5'(wrap_step({1'b0, hr}, 6'd23, edit_inc));
                        ST_SET_MIN: mn <= wrap_step(mn, 6'd59, edit_inc);
                        ST_SET_SEC: sc <= wrap_step(sc, 6'd59, edit_inc);
                        default:    ;
                    endcase
                end
            end
        end
    end

    // Display hour: 12-hour mode maps 0 -> 12 and 13..23 -> 1..11.
    always_comb begin
        disp_hr = hr;
        if (HOUR_24 == 0) begin
            if (hr == 5'd0) begin
                disp_hr = 5'd12;
            end else if (hr > 5'd12) begin
                disp_hr = hr - 5'd12;
            end
        end
    end

    assign time_bcd = {to_bcd({1'b0, disp_hr}), to_bcd(mn), to_bcd(sc)};
    assign pm       = (HOUR_24 == 0) && (hr >= 5'd12);
    assign mode     = state;

endmodule
